cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory/L2 port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined LC-3b core.
- Grants one requester at a time and forwards its command to memory.
- Holds that grant until memory answers, then routes the response back.
- Sits between the two L1 caches and physical memory; contains no storage beyond the latched command.

Parameters:
LINE_W, 128, cache line width in bits
ADDR_W, 16, byte address width
FIXED_D_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = data cache always wins ties

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
i_read  input  1  I-cache line-fill request
i_address  input  ADDR_W  I-cache line address
i_rdata  output  LINE_W  fill data to I-cache
i_resp  output  1  I-cache transaction done
d_read  input  1  D-cache line-fill request
d_write  input  1  D-cache writeback request
d_address  input  ADDR_W  D-cache line address
d_wdata  input  LINE_W  writeback data
d_rdata  output  LINE_W  fill data to D-cache
d_resp  output  1  D-cache transaction done
m_read  output  1  memory read command
m_write  output  1  memory write command
m_address  output  ADDR_W  memory address
m_wdata  output  LINE_W  memory write data
m_rdata  input  LINE_W  memory read data
m_resp  input  1  memory transaction done

Behaviour:
- Reset: clk and rst as named above; rst is asynchronous, active-high.
  - On reset: state=IDLE, last_grant=D, latched address/wdata/cmd=0.
  - On reset: m_read=m_write=0, i_resp=d_resp=0, i_rdata=d_rdata=0.
  - Reset mid-transaction drops the command immediately. A late m_resp after reset is ignored.
- States:
  - IDLE: no m_* command asserted. m_resp is ignored.
    - Only i_read pending -> SERVE_I.
    - Only d_read or d_write pending -> SERVE_D.
    - Both pending: FIXED_D_PRIO=1 -> SERVE_D. FIXED_D_PRIO=0 -> grant the requester not in last_grant.
    - The winner's address, wdata and cmd (read/write) are registered on the transition edge, and last_grant is updated.
  - SERVE_I: m_read=1, m_address=latched address.
    - On m_resp=1: i_resp=1 and i_rdata=m_rdata in the same cycle (combinational pass-through); next state IDLE.
  - SERVE_D: m_read or m_write per the latched cmd, with m_address and m_wdata from the latch.
    - On m_resp=1: d_resp=1 and d_rdata=m_rdata in the same cycle; next state IDLE.
- Latency:
  - Grant is issued one cycle after the request is seen in IDLE.
  - Total request-to-resp time = 1 + memory latency cycles.
  - The mandatory IDLE cycle after each resp lets the requester drop its request before re-arbitration, so no duplicate grant occurs.
- Handshake: requesters hold their request and data stable until resp. The arbiter uses only latched values during SERVE_*, so a request dropped mid-transaction does not abort memory. resp is still pulsed once.
- d_read and d_write asserted together is illegal; write takes precedence.
- The non-granted requester sees resp=0. Its rdata is driven 0, never stale memory data.
- Back-to-back: with both requesters continuously asserting under round-robin, grants strictly alternate I, D, I, D.
- m_resp arriving on the same cycle the requester deasserts still completes normally.

Decomposition:
- lc3b_types gains lc3b_c_line (LINE_W-bit line), the arb_state enum {IDLE, SERVE_I, SERVE_D}, and the arb_requester enum {REQ_I, REQ_D}.
- No sub-module needed. The tie-break selection stays inline as one always_comb block beside the FSM.

Test Plan:
- Reset during SERVE_D (d_write=1, addr 0x1230): assert rst mid-transfer -> m_write drops to 0 asynchronously; next m_resp produces no d_resp.
- Lone I fill: i_read=1, addr 0x0040; memory replies after 3 cycles with 0xDEAD...BEEF -> m_read rises cycle 1; i_resp=1 with that data at cycle 4; d_resp stays 0.
- Lone D writeback: d_write=1, addr 0x8000, wdata 0x1111...1111 -> m_write=1, m_wdata matches; d_resp pulses exactly once.
- Tie, FIXED_D_PRIO=0, from reset: i_read and d_read held high -> grants I, D, I, D, with one IDLE cycle between each.
- Tie, FIXED_D_PRIO=1: both requests held high -> D is granted first. After D deasserts, I is granted.
- Request dropped: i_read deasserted one cycle after grant -> m_read stays 1 until m_resp; i_resp pulses once; FSM returns to IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the L1-to-memory arbiter of the LC-3b pipelined core.
//   lc3b_c_line   : one cache line (128 bits)
//   arb_state     : arbiter FSM state
//   arb_requester : identifies which L1 cache holds (or last held) the grant
package cache_mem_arbiter_pkg;

   localparam int LC3B_LINE_W = 128;

   typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } arb_requester;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the single memory/L2 port between the I-cache fill path and the
// D-cache fill/writeback path. One requester is granted at a time; its
// command is latched on the grant edge and held on the memory port until
// m_resp, which is passed straight back to the granted cache.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_read, i_address        I-cache line-fill request
//   i_rdata, i_resp          I-cache fill data / transaction done
//   d_read, d_write          D-cache fill / writeback request (write wins)
//   d_address, d_wdata       D-cache line address / writeback data
//   d_rdata, d_resp          D-cache fill data / transaction done
//   m_read, m_write          memory command
//   m_address, m_wdata       memory address / write data (from the latch)
//   m_rdata, m_resp          memory read data / transaction done
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int LINE_W       = 128,
   parameter int ADDR_W       = 16,
   parameter int FIXED_D_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_address,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp
);

   arb_state          state;
   arb_requester      last_grant;
   logic [ADDR_W-1:0] lat_addr;
   logic [LINE_W-1:0] lat_wdata;
   logic              lat_write;

   logic i_req, d_req, grant_d;

   // Tie-break: on a simultaneous request either D always wins, or the
   // requester that did not hold the previous grant wins.
   always_comb begin
      i_req   = i_read;
      d_req   = d_read | d_write;
      grant_d = 1'b0;
      if (d_req && !i_req)
         grant_d = 1'b1;
      else if (d_req && i_req)
         grant_d = (FIXED_D_PRIO != 0) || (last_grant == REQ_I);
   end

   // Serving states always return to IDLE after m_resp; that idle cycle
   // gives the finished requester time to drop its request before the
   // next arbitration, so it is never granted twice for one transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= REQ_D;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_write  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  if (grant_d) begin
                     state      <= SERVE_D;
                     last_grant <= REQ_D;
                     lat_addr   <= d_address;
                     lat_wdata  <= d_wdata;
                     lat_write  <= d_write;
                  end else begin
                     state      <= SERVE_I;
                     last_grant <= REQ_I;
                     lat_addr   <= i_address;
                     lat_wdata  <= '0;
                     lat_write  <= 1'b0;
                  end
               end
            end
            SERVE_I, SERVE_D: begin
               if (m_resp) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Command comes only from the latch, so a requester dropping its
   // request mid-transaction cannot disturb the memory access. Because the
   // state resets asynchronously, the command also drops the moment rst rises.
   assign m_read    = (state == SERVE_I) || ((state == SERVE_D) && !lat_write);
   assign m_write   = (state == SERVE_D) && lat_write;
   assign m_address = lat_addr;
   assign m_wdata   = lat_wdata;

   // m_resp is only meaningful while serving; the non-granted side sees zeros.
   assign i_resp  = (state == SERVE_I) && m_resp;
   assign d_resp  = (state == SERVE_D) && m_resp;
   assign i_rdata = i_resp ? m_rdata : '0;
   assign d_rdata = d_resp ? m_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
   import cache_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // round-robin instance
   logic        i_read = 0, d_read = 0, d_write = 0, m_resp = 0;
   logic [15:0] i_address = 0, d_address = 0, m_address;
   lc3b_c_line  d_wdata = 0, m_rdata = 0, i_rdata, d_rdata, m_wdata;
   logic        i_resp, d_resp, m_read, m_write;

   // fixed-priority instance
   logic        i_read_f = 0, d_read_f = 0, d_write_f = 0, m_resp_f = 0;
   logic [15:0] i_address_f = 0, d_address_f = 0, m_address_f;
   lc3b_c_line  d_wdata_f = 0, m_rdata_f = 0, i_rdata_f, d_rdata_f, m_wdata_f;
   logic        i_resp_f, d_resp_f, m_read_f, m_write_f;

   cache_mem_arbiter #(.LINE_W(128), .ADDR_W(16), .FIXED_D_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp));

   cache_mem_arbiter #(.LINE_W(128), .ADDR_W(16), .FIXED_D_PRIO(1)) dut_f (
      .clk(clk), .rst(rst),
      .i_read(i_read_f), .i_address(i_address_f), .i_rdata(i_rdata_f), .i_resp(i_resp_f),
      .d_read(d_read_f), .d_write(d_write_f), .d_address(d_address_f), .d_wdata(d_wdata_f),
      .d_rdata(d_rdata_f), .d_resp(d_resp_f),
      .m_read(m_read_f), .m_write(m_write_f), .m_address(m_address_f), .m_wdata(m_wdata_f),
      .m_rdata(m_rdata_f), .m_resp(m_resp_f));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory contents never written read back as an address-derived pattern.
   function automatic lc3b_c_line pat(input logic [15:0] a);
      return {4{a, ~a}};
   endfunction

   // ---------------- reference model / scoreboard state ----------------
   lc3b_c_line mem   [logic [15:0]];   // physical memory behind the DUT
   lc3b_c_line dmodel[logic [15:0]];   // what the D-cache believes it wrote
   lc3b_c_line iq[$];
   lc3b_c_line dq[$];
   int         done_cnt;
   localparam int NTXN = 30;

   task automatic i_requester();
      for (int n = 0; n < NTXN; n++) begin
         logic [15:0] a;
         int          c;
         repeat ($urandom_range(0, 2)) tick();
         a = 16'($urandom_range(0, 16'h07FF)) << 4;
         i_address = a;
         i_read    = 1'b1;
         iq.push_back(pat(a));
         c = 0;
         do begin @(negedge clk); c++; end while (!i_resp && c < 200);
         if (!i_resp) chk("i_timeout", 1'b1, 1'b0);
         tick();
         i_read = 1'b0;
      end
      done_cnt++;
   endtask

   task automatic d_requester();
      for (int n = 0; n < NTXN; n++) begin
         logic [15:0] a;
         lc3b_c_line  w;
         int          c;
         repeat ($urandom_range(0, 2)) tick();
         a = 16'h8000 | (16'($urandom_range(0, 7)) << 4);
         d_address = a;
         if ($urandom_range(0, 1) == 1) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            d_wdata   = w;
            d_write   = 1'b1;
            dmodel[a] = w;
            dq.push_back('0);          // the memory returns zero data on writes
         end else begin
            d_read = 1'b1;
            dq.push_back(dmodel.exists(a) ? dmodel[a] : pat(a));
         end
         c = 0;
         do begin @(negedge clk); c++; end while (!d_resp && c < 200);
         if (!d_resp) chk("d_timeout", 1'b1, 1'b0);
         tick();
         d_read  = 1'b0;
         d_write = 1'b0;
      end
      done_cnt++;
   endtask

   // Memory with random 0..3 extra wait cycles.
   task automatic responder();
      int cnt = 0;
      int tgt = 0;
      while (done_cnt < 2) begin
         tick();
         if (m_resp) begin
            m_resp  = 1'b0;
            m_rdata = '0;
         end else if (m_read || m_write) begin
            if (cnt >= tgt) begin
               chk("m_rw_exclusive", m_read && m_write, 1'b0);
               if (m_write) begin
                  mem[m_address] = m_wdata;
                  m_rdata = '0;
               end else begin
                  m_rdata = mem.exists(m_address) ? mem[m_address] : pat(m_address);
               end
               m_resp = 1'b1;
               cnt = 0;
               tgt = $urandom_range(0, 3);
            end else begin
               cnt++;
            end
         end
      end
   endtask

   task automatic monitor();
      while (done_cnt < 2) begin
         @(negedge clk);
         chk("resp_exclusive", i_resp && d_resp, 1'b0);
         if (i_resp) begin
            if (iq.size() == 0) chk("i_resp_unexpected", 1'b1, 1'b0);
            else chk("i_rdata", i_rdata, iq.pop_front());
         end else chk("i_rdata_idle_zero", i_rdata, '0);
         if (d_resp) begin
            if (dq.size() == 0) chk("d_resp_unexpected", 1'b1, 1'b0);
            else chk("d_rdata", d_rdata, dq.pop_front());
         end else chk("d_rdata_idle_zero", d_rdata, '0);
      end
   endtask

   initial begin
      lc3b_c_line  dat;
      logic [15:0] exp_addr [4];
      int          pulses;

      // ---- reset values ----
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_read", m_read, 1'b0);
      chk("rst_m_write", m_write, 1'b0);
      chk("rst_m_address", m_address, '0);
      chk("rst_m_wdata", m_wdata, '0);
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      rst = 1'b0;
      tick();
      chk("rst_idle_no_cmd", m_read | m_write, 1'b0);

      // ---- lone I fill, memory latency 3 ----
      i_address = 16'h0040;
      i_read    = 1'b1;
      tick();
      chk("ifill_m_read_c1", m_read, 1'b1);
      chk("ifill_m_address", m_address, 16'h0040);
      tick();
      tick();
      tick();
      dat     = {32'hDEAD_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_BEEF};
      m_rdata = dat;
      m_resp  = 1'b1;
      #1;
      chk("ifill_i_resp_c4", i_resp, 1'b1);
      chk("ifill_i_rdata", i_rdata, dat);
      chk("ifill_d_resp", d_resp, 1'b0);
      chk("ifill_d_rdata_zero", d_rdata, '0);
      i_read = 1'b0;
      tick();
      m_resp  = 1'b0;
      m_rdata = '0;
      chk("ifill_back_idle", m_read, 1'b0);

      // ---- lone D writeback ----
      d_address = 16'h8000;
      d_wdata   = {32{4'h1}};
      d_write   = 1'b1;
      tick();
      chk("dwb_m_write", m_write, 1'b1);
      chk("dwb_m_read", m_read, 1'b0);
      chk("dwb_m_address", m_address, 16'h8000);
      chk("dwb_m_wdata", m_wdata, {32{4'h1}});
      tick();
      m_resp = 1'b1;
      pulses = 0;
      #1;
      if (d_resp) pulses++;
      d_write = 1'b0;
      tick();
      m_resp = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (d_resp) pulses++;
         tick();
      end
      chk("dwb_i_resp", i_resp, 1'b0);
      chk("dwb_d_resp_once", pulses, 1);

      // ---- request dropped after grant ----
      i_address = 16'h0200;
      i_read    = 1'b1;
      tick();
      chk("drop_granted", m_read, 1'b1);
      i_read = 1'b0;
      tick();
      chk("drop_m_read_held", m_read, 1'b1);
      chk("drop_m_address_held", m_address, 16'h0200);
      tick();
      m_rdata = pat(16'h0200);
      m_resp  = 1'b1;
      #1;
      chk("drop_i_resp", i_resp, 1'b1);
      chk("drop_i_rdata", i_rdata, pat(16'h0200));
      tick();
      m_resp  = 1'b0;
      m_rdata = '0;
      chk("drop_idle", m_read, 1'b0);
      tick();
      chk("drop_no_regrant", m_read, 1'b0);

      // ---- reset during SERVE_D ----
      d_address = 16'h1230;
      d_wdata   = {4{32'hCAFE_F00D}};
      d_write   = 1'b1;
      tick();
      chk("rstmid_m_write", m_write, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_m_write_async_drop", m_write, 1'b0);
      tick();
      rst     = 1'b0;
      d_write = 1'b0;
      m_resp  = 1'b1;
      #1;
      chk("rstmid_late_resp_ignored", d_resp, 1'b0);
      tick();
      m_resp = 1'b0;
      chk("rstmid_idle", m_write | m_read, 1'b0);

      // ---- tie under round-robin, last_grant reset to D -> I first ----
      exp_addr = '{16'h0100, 16'h9000, 16'h0100, 16'h9000};
      i_address = 16'h0100;
      d_address = 16'h9000;
      i_read    = 1'b1;
      d_read    = 1'b1;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("rr_grant_m_read", m_read, 1'b1);
         chk("rr_grant_order", m_address, exp_addr[g]);
         m_rdata = pat(exp_addr[g]);
         m_resp  = 1'b1;
         #1;
         chk("rr_i_resp", i_resp, (g % 2) == 0);
         chk("rr_d_resp", d_resp, (g % 2) == 1);
         tick();
         m_resp  = 1'b0;
         m_rdata = '0;
         chk("rr_idle_gap", m_read, 1'b0);
      end
      i_read = 1'b0;
      d_read = 1'b0;
      tick();

      // ---- tie under fixed D priority ----
      i_address_f = 16'h0100;
      d_address_f = 16'h9000;
      i_read_f    = 1'b1;
      d_read_f    = 1'b1;
      tick();
      chk("fix_d_first", m_address_f, 16'h9000);
      chk("fix_m_read", m_read_f, 1'b1);
      m_resp_f = 1'b1;
      #1;
      chk("fix_d_resp", d_resp_f, 1'b1);
      tick();
      m_resp_f = 1'b0;
      d_read_f = 1'b0;
      chk("fix_idle_gap", m_read_f, 1'b0);
      tick();
      chk("fix_i_next", m_address_f, 16'h0100);
      chk("fix_i_m_read", m_read_f, 1'b1);
      m_resp_f = 1'b1;
      #1;
      chk("fix_i_resp", i_resp_f, 1'b1);
      tick();
      m_resp_f = 1'b0;
      i_read_f = 1'b0;

      // ---- randomized traffic against the memory/scoreboard model ----
      done_cnt = 0;
      fork
         i_requester();
         d_requester();
         responder();
         monitor();
      join
      m_resp = 1'b0;
      chk("iq_drained", iq.size(), 0);
      chk("dq_drained", dq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
